// File: rtl/aha_tlx_training_lane.sv
// Single-bit TLX link-training lane: RX compares a sliding window against the
// training word and counts hits; TX serialises the word or passes data through.
module aha_tlx_training_lane #(
    parameter int SEQ_W = 32
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             d_in_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic [SEQ_W-1:0] sequence_i,
    input  logic [SEQ_W-1:0] length_i,
    input  logic             auto_stop_i,
    input  logic             mode_i,
    output logic             done_o,
    output logic             active_o,
    output logic [SEQ_W-1:0] match_count_o,
    output logic             d_out_o
);

    localparam int                IDX_W     = $clog2(SEQ_W);
    localparam logic [IDX_W:0]    FILL_FULL = (IDX_W+1)'(SEQ_W);
    localparam logic [IDX_W-1:0]  TOP_IDX   = IDX_W'(SEQ_W - 1);

    logic             active_q;
    logic             done_q;
    logic [SEQ_W-1:0] match_count_q;
    logic [SEQ_W-1:0] cycle_cnt_q;
    logic [IDX_W:0]   fill_cnt_q;
    logic [IDX_W-1:0] bit_idx_q;
    logic [SEQ_W-1:0] rx_sr_q;
    logic             tx_q;

    logic [SEQ_W-1:0] rx_sr_d;
    logic [IDX_W:0]   fill_cnt_d;
    logic [SEQ_W-1:0] cycle_cnt_d;
    logic [SEQ_W-1:0] match_count_d;
    logic             match_hit;
    logic             len_hit;

    always_comb begin
        rx_sr_d       = {rx_sr_q[SEQ_W-2:0], d_in_i};
        fill_cnt_d    = (fill_cnt_q == FILL_FULL) ? fill_cnt_q : fill_cnt_q + 1'b1;
        cycle_cnt_d   = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + 1'b1;
        // Compare the window as it will be after this cycle's shift.
        match_hit     = (fill_cnt_d == FILL_FULL) && (rx_sr_d == sequence_i);
        match_count_d = (match_hit && !(&match_count_q)) ? match_count_q + 1'b1
                                                        : match_count_q;
        len_hit       = (length_i != '0) && (cycle_cnt_q == length_i - 1'b1);
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            active_q      <= 1'b0;
            done_q        <= 1'b0;
            match_count_q <= '0;
            cycle_cnt_q   <= '0;
            fill_cnt_q    <= '0;
            bit_idx_q     <= '0;
            rx_sr_q       <= '0;
            tx_q          <= 1'b0;
        end else if (clear_i || start_i) begin
            // Clear wins over start; rx_sr is left alone since fill_cnt gates compares.
            active_q      <= !clear_i;
            done_q        <= 1'b0;
            match_count_q <= '0;
            cycle_cnt_q   <= '0;
            fill_cnt_q    <= '0;
            bit_idx_q     <= '0;
            tx_q          <= 1'b0;
        end else if (active_q) begin
            rx_sr_q       <= rx_sr_d;
            fill_cnt_q    <= fill_cnt_d;
            match_count_q <= match_count_d;
            tx_q          <= sequence_i[TOP_IDX - bit_idx_q];
            bit_idx_q     <= bit_idx_q + 1'b1;
            cycle_cnt_q   <= cycle_cnt_d;
            if (len_hit) begin
                done_q <= 1'b1;
                if (auto_stop_i) active_q <= 1'b0;
            end
        end else begin
            tx_q <= 1'b0;
        end
    end

    assign done_o        = done_q;
    assign active_o      = active_q;
    assign match_count_o = match_count_q;
    assign d_out_o       = mode_i ? tx_q : d_in_i;

endmodule

// File: tb/tb_aha_tlx_training_lane.sv
// Directed bench: a TX lane looped into an RX lane, with hand-computed expectations.
module tb_aha_tlx_training_lane;

    localparam logic [31:0] SEQ = 32'h5A6B7C8D;

    logic        clk = 1'b0;
    logic        resetn, start, clear, d_in, loop_en, mode_tx, mode_rx, auto_stop;
    logic [31:0] seq_tx, seq_rx, length;

    logic        tx_done, tx_active, tx_dout;
    logic [31:0] tx_match;
    logic        rx_done, rx_active, rx_dout, rx_din;
    logic [31:0] rx_match;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign rx_din = loop_en ? tx_dout : d_in;

    aha_tlx_training_lane u_tx (
        .clk_i(clk), .resetn_i(resetn), .d_in_i(d_in), .start_i(start), .clear_i(clear),
        .sequence_i(seq_tx), .length_i(length), .auto_stop_i(auto_stop), .mode_i(mode_tx),
        .done_o(tx_done), .active_o(tx_active), .match_count_o(tx_match), .d_out_o(tx_dout)
    );

    aha_tlx_training_lane u_rx (
        .clk_i(clk), .resetn_i(resetn), .d_in_i(rx_din), .start_i(start), .clear_i(clear),
        .sequence_i(seq_rx), .length_i(length), .auto_stop_i(auto_stop), .mode_i(mode_rx),
        .done_o(rx_done), .active_o(rx_active), .match_count_o(rx_match), .d_out_o(rx_dout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [31:0] word;
    logic        any_bit;

    initial begin
        resetn = 1'b0; start = 1'b0; clear = 1'b0; d_in = 1'b0; loop_en = 1'b0;
        mode_tx = 1'b1; mode_rx = 1'b1; auto_stop = 1'b1; length = '0;
        seq_tx = SEQ; seq_rx = SEQ;

        // T1 reset with toggling input
        for (int i = 0; i < 3; i++) begin
            d_in = ~d_in;
            tick();
        end
        check("rst_active", {31'd0, tx_active}, 32'd0);
        check("rst_done", {31'd0, rx_done}, 32'd0);
        check("rst_match", rx_match, 32'd0);
        check("rst_dout", {31'd0, tx_dout}, 32'd0);
        resetn = 1'b1;
        tick();

        // T2 loopback, 256-cycle run with auto stop
        length = 32'h100; auto_stop = 1'b1; loop_en = 1'b1;
        pulse_start();
        check("t2_active_rise", {30'd0, tx_active, rx_active}, 32'd3);
        word = '0;
        for (int k = 1; k <= 256; k++) begin
            tick();
            if (k <= 32) word = {word[30:0], tx_dout};
            if (k == 32) begin
                check("t2_tx_word", word, SEQ);
                check("t2_match_k32", rx_match, 32'd0);
            end
            if (k == 33) check("t2_match_k33", rx_match, 32'd1);
            if (k == 255) check("t2_pre_done", {30'd0, rx_active, rx_done}, 32'd2);
        end
        check("t2_end_flags", {30'd0, rx_active, rx_done}, 32'd1);
        check("t2_tx_inactive", {31'd0, tx_active}, 32'd0);
        check("t2_match_total", rx_match, 32'd7);

        // T3 passthrough then pattern
        loop_en = 1'b0; mode_tx = 1'b0; length = '0;
        pulse_start();
        d_in = 1'b1; #1;
        check("t3_pass1", {31'd0, tx_dout}, 32'd1);
        d_in = 1'b0; #1;
        check("t3_pass0", {31'd0, tx_dout}, 32'd0);
        tick();
        d_in = 1'b1; #1;
        check("t3_pass1b", {31'd0, tx_dout}, 32'd1);
        mode_tx = 1'b1; #1;
        word = {31'd0, tx_dout};
        for (int k = 2; k <= 4; k++) begin
            tick();
            word = {word[30:0], tx_dout};
        end
        check("t3_msb_first", word, 32'h5);
        clear = 1'b1; tick(); clear = 1'b0;
        check("t3_cleared", {31'd0, tx_active}, 32'd0);

        // T4 no auto stop
        loop_en = 1'b1; length = 32'd16; auto_stop = 1'b0;
        pulse_start();
        for (int k = 1; k <= 65; k++) begin
            tick();
            if (k == 15) check("t4_done_k15", {31'd0, rx_done}, 32'd0);
            if (k == 16) check("t4_done_k16", {30'd0, rx_active, rx_done}, 32'd3);
            if (k == 33) check("t4_match_k33", rx_match, 32'd1);
            if (k == 65) begin
                check("t4_match_k65", rx_match, 32'd2);
                check("t4_still_on", {30'd0, rx_active, rx_done}, 32'd3);
            end
        end
        clear = 1'b1; tick(); clear = 1'b0;
        check("t4_clear_flags", {30'd0, rx_active, rx_done}, 32'd0);
        check("t4_clear_match", rx_match, 32'd0);

        // T5 event priority
        start = 1'b1; clear = 1'b1; tick(); start = 1'b0; clear = 1'b0;
        check("t5_clear_wins", {30'd0, tx_active, rx_active}, 32'd0);
        pulse_start();
        for (int k = 1; k <= 40; k++) tick();
        check("t5_pre_restart", {rx_match[29:0], rx_done, rx_active}, 32'd7);
        pulse_start();
        check("t5_restart", {rx_match[29:0], rx_done, rx_active}, 32'd1);
        for (int k = 1; k <= 33; k++) tick();
        check("t5_rerun_match", rx_match, 32'd1);
        resetn = 1'b0; tick(); resetn = 1'b1;
        check("t5_reset_mid", {rx_match[29:0], rx_done, rx_active}, 32'd0);

        // T6 live sequence change on TX
        seq_tx = '0; seq_rx = SEQ; length = '0; auto_stop = 1'b1; loop_en = 1'b1;
        pulse_start();
        any_bit = 1'b0;
        for (int k = 1; k <= 129; k++) begin
            tick();
            if (k <= 40) any_bit = any_bit | tx_dout;
            if (k == 40) begin
                check("t6_zero_stream", {31'd0, any_bit}, 32'd0);
                check("t6_match_k40", rx_match, 32'd0);
                seq_tx = SEQ;
            end
            if (k == 42) check("t6_live_bit", {31'd0, tx_dout}, 32'd1);
            if (k == 96) check("t6_match_k96", rx_match, 32'd0);
            if (k == 97) check("t6_match_k97", rx_match, 32'd1);
            if (k == 129) check("t6_match_k129", rx_match, 32'd2);
        end
        clear = 1'b1; tick(); clear = 1'b0;
        check("t6_cleared", {rx_match[29:0], rx_done, rx_active}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
